// File: rtl/pipelined_controller_pkg.sv
// rtl/pipelined_controller_pkg.sv - shared control encodings for the RV32I-subset pipeline
//
// Purpose: opcode constants, ALUOp / ALUControl / ResultSrc / ImmSrc encodings
//          and the decode->execute control bundle. The alu and datapath use the
//          same encodings.
// Ports:   none (package)

package pipelined_controller_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_control_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Controls carried from decode into execute. All-zero is a bubble.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_control;
    } de_ctrl_t;

    // Controls carried from execute into memory.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } em_ctrl_t;

    // Controls carried from memory into writeback.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } mw_ctrl_t;

endpackage

// File: rtl/pipelined_controller_alu_decoder.sv
// rtl/pipelined_controller_alu_decoder.sv - ALUOp/funct field to ALU operation decode
//
// Purpose: combinational ALU control decode.
// Ports:   alu_op      - class of operation from the main decoder
//          funct3      - instruction funct3 field
//          op_b5       - opcode bit 5 (distinguishes R-type from I-type ALU)
//          funct7      - instruction bit 30
//          alu_control - ALU operation code

module alu_decoder
    import pipelined_controller_pkg::*;
(
    input  alu_op_e     alu_op,
    input  logic [2:0]  funct3,
    input  logic        op_b5,
    input  logic        funct7,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // Only R-type uses funct7 to select sub; addi never subtracts.
                    3'b000:  alu_control = (op_b5 & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/pipelined_controller.sv
// rtl/pipelined_controller.sv - pipelined RV32I-subset control unit (D/E/M/W stages)
//
// Purpose: decodes the D-stage opcode and carries the controls down the
//          E, M and W stages. Optional feature macro BNE_SUPPORT_EN: when
//          defined, funct3[0] is carried into execute and branch opcodes with
//          funct3[0]=1 take the branch on ZeroE=0 (bne); otherwise every branch
//          behaves as beq.
// Ports:   CLK, RESET (async, active-low)
//          OP, funct3, funct7 - D-stage instruction fields
//          ZeroE              - ALU zero flag from execute
//          FlushE             - turn the D->E register into a bubble
//          ImmSrcD            - immediate format (combinational)
//          PCSrcE, ALUSrcE, ALUControlE, ResultSrcE0 - execute controls
//          MemWriteM, RegWriteM                      - memory-stage controls
//          RegWriteW, ResultSrcW                     - writeback controls

module pipelined_controller
    import pipelined_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [6:0]  OP,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        ZeroE,
    input  logic        FlushE,
    output logic [1:0]  ImmSrcD,
    output logic        PCSrcE,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        MemWriteM,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        ResultSrcE0,
    output logic [1:0]  ResultSrcW
);

    // ---------------- decode stage ----------------
    logic       reg_write_dec;
    logic [1:0] result_src_dec;
    logic       mem_write_dec;
    logic       jump_dec;
    logic       branch_dec;
    logic       alu_src_dec;
    alu_op_e    alu_op_dec;
    logic [1:0] imm_src_dec;
    logic [2:0] alu_control_dec;

    always_comb begin
        reg_write_dec  = 1'b0;
        result_src_dec = RES_ALU;
        mem_write_dec  = 1'b0;
        jump_dec       = 1'b0;
        branch_dec     = 1'b0;
        alu_src_dec    = 1'b0;
        alu_op_dec     = ALUOP_ADD;
        imm_src_dec    = IMM_I;
        case (OP)
            OP_LW: begin
                reg_write_dec  = 1'b1;
                alu_src_dec    = 1'b1;
                result_src_dec = RES_MEM;
            end
            OP_SW: begin
                imm_src_dec   = IMM_S;
                alu_src_dec   = 1'b1;
                mem_write_dec = 1'b1;
            end
            OP_RTYPE: begin
                reg_write_dec = 1'b1;
                alu_op_dec    = ALUOP_FUNC;
            end
            OP_BEQ: begin
                imm_src_dec = IMM_B;
                branch_dec  = 1'b1;
                alu_op_dec  = ALUOP_SUB;
            end
            OP_IALU: begin
                reg_write_dec = 1'b1;
                alu_src_dec   = 1'b1;
                alu_op_dec    = ALUOP_FUNC;
            end
            OP_JAL: begin
                reg_write_dec  = 1'b1;
                imm_src_dec    = IMM_J;
                result_src_dec = RES_PC4;
                jump_dec       = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_dec),
        .funct3      (funct3),
        .op_b5       (OP[5]),
        .funct7      (funct7),
        .alu_control (alu_control_dec)
    );

    assign ImmSrcD = imm_src_dec;

    // ---------------- D->E register ----------------
    de_ctrl_t de_d, de_q;

    always_comb begin
        de_d = '0;
        if (!FlushE) begin
            de_d.reg_write   = reg_write_dec;
            de_d.result_src  = result_src_dec;
            de_d.mem_write   = mem_write_dec;
            de_d.jump        = jump_dec;
            de_d.branch      = branch_dec;
            de_d.alu_src     = alu_src_dec;
            de_d.alu_control = alu_control_dec;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

`ifdef BNE_SUPPORT_EN
    // funct3[0] separates bne from beq; cleared with the rest on a flush.
    logic funct3_b0_d, funct3_b0_q;

    always_comb begin
        funct3_b0_d = FlushE ? 1'b0 : funct3[0];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            funct3_b0_q <= 1'b0;
        end else begin
            funct3_b0_q <= funct3_b0_d;
        end
    end

    logic branch_cond;
    assign branch_cond = funct3_b0_q ? ~ZeroE : ZeroE;
`else
    logic branch_cond;
    assign branch_cond = ZeroE;
`endif

    assign PCSrcE      = de_q.jump | (de_q.branch & branch_cond);
    assign ALUSrcE     = de_q.alu_src;
    assign ALUControlE = de_q.alu_control;
    assign ResultSrcE0 = de_q.result_src[0];

    // ---------------- E->M register ----------------
    em_ctrl_t em_d, em_q;

    always_comb begin
        em_d.reg_write  = de_q.reg_write;
        em_d.result_src = de_q.result_src;
        em_d.mem_write  = de_q.mem_write;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            em_q <= '0;
        end else begin
            em_q <= em_d;
        end
    end

    assign MemWriteM = em_q.mem_write;
    assign RegWriteM = em_q.reg_write;

    // ---------------- M->W register ----------------
    mw_ctrl_t mw_d, mw_q;

    always_comb begin
        mw_d.reg_write  = em_q.reg_write;
        mw_d.result_src = em_q.result_src;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mw_q <= '0;
        end else begin
            mw_q <= mw_d;
        end
    end

    assign RegWriteW  = mw_q.reg_write;
    assign ResultSrcW = mw_q.result_src;

endmodule

// File: tb/tb_pipelined_controller.sv
// tb/tb_pipelined_controller.sv - self-checking bench for pipelined_controller

module tb_pipelined_controller;

    logic       CLK;
    logic       RESET;
    logic [6:0] OP;
    logic [2:0] funct3;
    logic       funct7;
    logic       ZeroE;
    logic       FlushE;
    logic [1:0] ImmSrcD;
    logic       PCSrcE;
    logic       ALUSrcE;
    logic [2:0] ALUControlE;
    logic       MemWriteM;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       ResultSrcE0;
    logic [1:0] ResultSrcW;

    pipelined_controller dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .OP          (OP),
        .funct3      (funct3),
        .funct7      (funct7),
        .ZeroE       (ZeroE),
        .FlushE      (FlushE),
        .ImmSrcD     (ImmSrcD),
        .PCSrcE      (PCSrcE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .MemWriteM   (MemWriteM),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE0 (ResultSrcE0),
        .ResultSrcW  (ResultSrcW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // One instruction's worth of control, as the reference model sees it.
    typedef struct {
        bit       rw;
        bit [1:0] rs;
        bit       mw;
        bit       j;
        bit       b;
        bit       as;
        bit [2:0] ac;
        bit       f0;
    } ctl_t;

    ctl_t stage_e, stage_m, stage_w;
    ctl_t zero_ctl;

    function automatic ctl_t model_decode(bit [6:0] op, bit [2:0] f3, bit f7);
        ctl_t c;
        int   aluop;
        c = zero_ctl;
        aluop = 0;
        case (op)
            7'b0000011: begin c.rw = 1; c.as = 1; c.rs = 2'b01; end
            7'b0100011: begin c.as = 1; c.mw = 1; end
            7'b0110011: begin c.rw = 1; aluop = 2; end
            7'b1100011: begin c.b = 1; aluop = 1; end
            7'b0010011: begin c.rw = 1; c.as = 1; aluop = 2; end
            7'b1101111: begin c.rw = 1; c.rs = 2'b10; c.j = 1; end
            default: ;
        endcase
        if (aluop == 1) c.ac = 3'd1;
        else if (aluop == 2) begin
            if (f3 == 3'd0)      c.ac = (op[5] && f7) ? 3'd1 : 3'd0;
            else if (f3 == 3'd2) c.ac = 3'd5;
            else if (f3 == 3'd6) c.ac = 3'd3;
            else if (f3 == 3'd7) c.ac = 3'd2;
            else                 c.ac = 3'd0;
        end
        c.f0 = f3[0];
        return c;
    endfunction

    function automatic bit [1:0] model_imm(bit [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit model_pcsrc(ctl_t e, bit zero);
        bit taken_on;
        taken_on = zero;
`ifdef BNE_SUPPORT_EN
        if (e.f0) taken_on = !zero;
`endif
        return e.j || (e.b && taken_on);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        chk("ImmSrcD", {6'd0, ImmSrcD}, {6'd0, model_imm(OP)});
        chk("PCSrcE", {7'd0, PCSrcE}, {7'd0, model_pcsrc(stage_e, ZeroE)});
    endtask

    task automatic check_regs();
        chk("ALUSrcE",     {7'd0, ALUSrcE},     {7'd0, stage_e.as});
        chk("ALUControlE", {5'd0, ALUControlE}, {5'd0, stage_e.ac});
        chk("ResultSrcE0", {7'd0, ResultSrcE0}, {7'd0, stage_e.rs[0]});
        chk("MemWriteM",   {7'd0, MemWriteM},   {7'd0, stage_m.mw});
        chk("RegWriteM",   {7'd0, RegWriteM},   {7'd0, stage_m.rw});
        chk("RegWriteW",   {7'd0, RegWriteW},   {7'd0, stage_w.rw});
        chk("ResultSrcW",  {6'd0, ResultSrcW},  {6'd0, stage_w.rs});
    endtask

    // Drive one D-stage instruction, check the combinational outputs, clock it
    // in, advance the model, and check the registered outputs on the falling edge.
    task automatic cycle(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                         input bit zero, input bit flush);
        OP = op; funct3 = f3; funct7 = f7; ZeroE = zero; FlushE = flush;
        #1;
        check_comb();
        @(posedge CLK);
        if (!RESET) begin
            stage_w = zero_ctl; stage_m = zero_ctl; stage_e = zero_ctl;
        end else begin
            stage_w = stage_m;
            stage_m = stage_e;
            stage_e = flush ? zero_ctl : model_decode(op, f3, f7);
        end
        @(negedge CLK);
        check_regs();
        check_comb();
    endtask

    function automatic bit [6:0] pick_op();
        case ($urandom_range(0, 6))
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0110011;
            3: return 7'b1100011;
            4: return 7'b0010011;
            5: return 7'b1101111;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        zero_ctl = '{default: 0};
        stage_e = zero_ctl; stage_m = zero_ctl; stage_w = zero_ctl;

        // Reset held low with random opcodes: everything registered reads 0.
        RESET = 1'b0;
        OP = 7'($urandom); funct3 = 3'($urandom); funct7 = 1'($urandom);
        ZeroE = 1'b0; FlushE = 1'b0;
        #2;
        check_regs();
        for (int i = 0; i < 3; i++)
            cycle(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        // Release at a falling edge, then an R-type sub.
        RESET = 1'b1;
        #1;
        check_regs();
        cycle(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("sub_ALUControlE", {5'd0, ALUControlE}, 8'h01);
        cycle(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("sub_RegWriteW", {7'd0, RegWriteW}, 8'h01);

        // Load: ResultSrcE0/ALUSrcE next edge, ResultSrcW=01 at the third edge.
        cycle(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        chk("lw_ResultSrcE0", {7'd0, ResultSrcE0}, 8'h01);
        chk("lw_ALUSrcE", {7'd0, ALUSrcE}, 8'h01);
        cycle(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("lw_ResultSrcW", {6'd0, ResultSrcW}, 8'h01);
        chk("lw_RegWriteW", {7'd0, RegWriteW}, 8'h01);

        // Branch: taken on ZeroE=1, not taken on ZeroE=0 (beq).
        cycle(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0);
        ZeroE = 1'b1; #1;
        chk("beq_z1_PCSrcE", {7'd0, PCSrcE}, 8'h01);
        ZeroE = 1'b0; #1;
        chk("beq_z0_PCSrcE", {7'd0, PCSrcE}, 8'h00);
`ifdef BNE_SUPPORT_EN
        cycle(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
        ZeroE = 1'b0; #1;
        chk("bne_z0_PCSrcE", {7'd0, PCSrcE}, 8'h01);
        ZeroE = 1'b1; #1;
        chk("bne_z1_PCSrcE", {7'd0, PCSrcE}, 8'h00);
`else
        cycle(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
        ZeroE = 1'b0; #1;
        chk("b001_z0_PCSrcE", {7'd0, PCSrcE}, 8'h00);
        ZeroE = 1'b1; #1;
        chk("b001_z1_PCSrcE", {7'd0, PCSrcE}, 8'h01);
`endif

        // Store flushed at its capture edge never writes memory.
        cycle(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cycle(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("flush_MemWriteM", {7'd0, MemWriteM}, 8'h00);

        // Jump: taken regardless of ZeroE; PC+4 written back.
        cycle(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        ZeroE = 1'b1; #1;
        chk("jal_z1_PCSrcE", {7'd0, PCSrcE}, 8'h01);
        ZeroE = 1'b0; #1;
        chk("jal_z0_PCSrcE", {7'd0, PCSrcE}, 8'h01);
        cycle(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("jal_ResultSrcW", {6'd0, ResultSrcW}, 8'h02);
        chk("jal_RegWriteW", {7'd0, RegWriteW}, 8'h01);
        cycle(7'b1111111, 3'b111, 1'b1, 1'b1, 1'b0);
        cycle(7'b1111111, 3'b111, 1'b1, 1'b1, 1'b0);
        chk("illegal_RegWriteW", {7'd0, RegWriteW}, 8'h00);
        chk("illegal_ALUControlE", {5'd0, ALUControlE}, 8'h00);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++)
            cycle(pick_op(), 3'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0));

        // Asynchronous reset mid-stream clears everything at once.
        cycle(7'b1101111, 3'b000, 1'b0, 1'b1, 1'b0);
        cycle(7'b0100011, 3'b000, 1'b0, 1'b1, 1'b0);
        RESET = 1'b0;
        stage_e = zero_ctl; stage_m = zero_ctl; stage_w = zero_ctl;
        #1;
        check_regs();
        check_comb();
        cycle(7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0);
        RESET = 1'b1;
        for (int i = 0; i < 20; i++)
            cycle(pick_op(), 3'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
